act_pwl_unit: RTL and testbench
===============================

// Module: act_pwl_unit
// PURPOSE
//  Parametrised piecewise-linear activation unit: CH lanes of signed fixed-point samples in, sigmoid (or tanh) out.
//  Segment table (breakpoint/shift/bias) is run-time programmable; reset loads the default sigmoid table.
//  Sits between accumulator output and next-layer buffer; 3-stage pipeline, valid/ready handshake with backpressure.
// PARAMETERS
//  DATA_W   16  sample width, signed two's complement, in and out
//  FRAC_W   8   fractional bits (ONE = 1<<FRAC_W)
//  NSEG     8   table entries (power of 2, >=2)
//  SHIFT_W  4   slope-shift field width; all-ones code = zero slope
//  CH       4   parallel lanes sharing one table
// PORTS
//  clk        in   1                clock, rising edge
//  rst        in   1                asynchronous, active-high reset
//  in_valid   in   1                input beat valid
//  in_ready   out  1                unit accepts beat
//  in_data    in   CH*DATA_W        lane i at [i*DATA_W +: DATA_W]
//  out_valid  out  1                output beat valid
//  out_ready  in   1                downstream accepts beat
//  out_data   out  CH*DATA_W        results, same lane packing
//  cfg_we     in   1                table write strobe
//  cfg_addr   in   $clog2(NSEG)     entry index
//  cfg_bp     in   DATA_W           signed breakpoint
//  cfg_shift  in   SHIFT_W          slope = 2^-shift
//  cfg_bias   in   DATA_W           signed bias (Q format)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, all stage valids=0, table=SIGMOID_DEFAULT; in-flight beats discarded.
//  - Transfer on valid&&ready each side. in_ready = out_ready || !out_valid (combinational from out_ready only).
//  - Latency 3 cycles accept->out_valid with no stall; throughput 1 beat/cycle.
//  - Stall: out_valid&&!out_ready freezes all stages and out_data; no beat lost, duplicated or reordered.
//  - Bubbles collapse: an empty stage advances even when a later stage is stalled.
//  - S1: per lane k = highest index with bp[k] <= x (signed compare); if x < bp[k] for all k -> zero flag.
//        Register x, bp[k], shift[k], bias[k], zero.  S2: d = x - bp[k] (DATA_W+1 bits), t = d >>> shift
//        (t=0 if shift all-ones).  S3: y = zero ? 0 : t + bias, saturated to [0, ONE-1].
//  - Table writes take effect on the cycle after cfg_we; a beat accepted in the same cycle as a write
//    uses the old entry; beats already past S1 are unaffected. Writes allowed during stalls.
//  - Unsorted breakpoints are legal; selection rule above still defines the result.
// CONFIGURATION
//  ACT_PWL_TANH_EN defined: adds register mode bit written by cfg_we with cfg_addr all-ones AND cfg_shift
//    all-ones AND cfg_bias MSB set? -> no: adds input cfg_mode (1 bit, sampled with cfg_we); mode=1 selects
//    tanh: x' = sat(2x), y = sat(2*s(x') - ONE) to [-ONE, ONE-1]; mode resets to 0.
//  Undefined: no cfg_mode port, sigmoid only, no extra pipeline stage in either build.
// STRUCTURE
//  act_pwl_pkg: seg_t struct {bp, shift, bias}, ONE, SHIFT_ZERO code, SIGMOID_DEFAULT[NSEG] constant.
//  act_pwl_lane: one-lane S1..S3 datapath, generated CH times; top holds table, handshake, stall control.
// TESTING
//  1 Reset, no stimulus -> out_valid=0, out_data=0, in_ready=1.
//  2 Program entry0 bp=0x0000 shift=0 bias=0, others bp=0x7FFF; x=0x0010 -> y=0x0010 after 3 cycles;
//    x=0xFFF0 -> y=0x0000 (zero flag); x=0x0200 -> y=0x00FF (saturated).
//  3 Entry0 bp=0x0000 shift=all-ones bias=0x0040 -> any x>=0 gives 0x0040 (zero slope).
//  4 Stream 16 beats, out_ready low cycles 5-8 -> all 16 outputs in order, none dropped/duplicated.
//  5 Write entry0 bias 0x0000->0x0020 same cycle as beat A, beat B next cycle -> A uses 0x0000, B 0x0020.
//  6 Assert rst with 2 beats in flight -> out_valid=0 immediately, table back to default, no stale output.

Source files
------------

// File: rtl/act_pwl_pkg.sv
// act_pwl_pkg: shared types and constants for the piecewise-linear activation unit.
// Holds the segment record, fixed-point constants and the reset-time sigmoid table.
package act_pwl_pkg;

   localparam int P_DATA_W  = 16;
   localparam int P_FRAC_W  = 8;
   localparam int P_NSEG    = 8;
   localparam int P_SHIFT_W = 4;
   localparam int P_CH      = 4;

   localparam int ONE = 1 << P_FRAC_W;

   // Shift code reserved for a flat (zero-slope) segment
   localparam logic [P_SHIFT_W-1:0] SHIFT_ZERO = '1;

   typedef struct packed {
      logic signed [P_DATA_W-1:0] bp;
      logic [P_SHIFT_W-1:0]       shift;
      logic signed [P_DATA_W-1:0] bias;
   } seg_t;

   // Sigmoid approximation over [-5, 5] in Q8.8; outer segments are flat
   localparam seg_t SIGMOID_DEFAULT [P_NSEG] = '{
      '{16'h8000, SHIFT_ZERO, 16'd0},
      '{16'hFB00, 4'd5,       16'd2},
      '{16'hFDA0, 4'd3,       16'd22},
      '{16'hFF00, 4'd2,       16'd64},
      '{16'h0000, 4'd2,       16'(ONE / 2)},
      '{16'h0100, 4'd3,       16'd192},
      '{16'h0260, 4'd5,       16'd235},
      '{16'h0500, SHIFT_ZERO, 16'(ONE - 1)}
   };

endpackage

// File: rtl/act_pwl_unit_lane.sv
// act_pwl_lane: one lane of the three-stage segment-select / shift / bias datapath.
// Optional tanh mode (ACT_PWL_TANH_EN) pre-scales x and re-maps the sigmoid result.
module act_pwl_lane
   import act_pwl_pkg::*;
#(
   parameter int DATA_W = P_DATA_W,
   parameter int FRAC_W = P_FRAC_W,
   parameter int NSEG   = P_NSEG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en1,
   input  logic              en2,
   input  logic              en3,
`ifdef ACT_PWL_TANH_EN
   input  logic              mode,
`endif
   input  logic [DATA_W-1:0] x,
   input  seg_t              tbl [NSEG],
   output logic [DATA_W-1:0] y
);

   localparam logic signed [DATA_W+1:0] SMAX =
      (DATA_W+2)'((1 << FRAC_W) - 1);

   logic signed [DATA_W-1:0] xs;
   seg_t                     sel;
   logic                     hit;

   logic signed [DATA_W-1:0] x1;
   seg_t                     s1;
   logic                     z1;

   logic signed [DATA_W:0]   d;
   logic signed [DATA_W:0]   t;
   logic signed [DATA_W:0]   t2;
   logic signed [DATA_W-1:0] b2;
   logic                     z2;

   logic signed [DATA_W+1:0] sum;
   logic [DATA_W-1:0]        sg;
   logic [DATA_W-1:0]        yn;

`ifdef ACT_PWL_TANH_EN
   logic m1;
   logic m2;
`endif

   // Highest-index segment whose breakpoint is <= x wins; none -> zero
   always_comb begin
      xs = $signed(x);
`ifdef ACT_PWL_TANH_EN
      if (mode) begin
         if (x[DATA_W-1] != x[DATA_W-2])
            xs = x[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
         else
            xs = {x[DATA_W-2:0], 1'b0};
      end
`endif
      sel = tbl[0];
      hit = 1'b0;
      for (int k = 0; k < NSEG; k++) begin
         if ($signed(tbl[k].bp) <= xs) begin
            sel = tbl[k];
            hit = 1'b1;
         end
      end
   end

   // Stage 1 register: sample and its selected segment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x1 <= '0;
         s1 <= '0;
         z1 <= 1'b0;
`ifdef ACT_PWL_TANH_EN
         m1 <= 1'b0;
`endif
      end else if (en1) begin
         x1 <= xs;
         s1 <= sel;
         z1 <= !hit;
`ifdef ACT_PWL_TANH_EN
         m1 <= mode;
`endif
      end
   end

   // Offset from breakpoint, scaled by the power-of-two slope
   always_comb begin
      d = {x1[DATA_W-1], x1} - {s1.bp[DATA_W-1], s1.bp};
      if (s1.shift == SHIFT_ZERO)
         t = '0;
      else
         t = d >>> s1.shift;
   end

   // Stage 2 register: scaled offset plus bias to add
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t2 <= '0;
         b2 <= '0;
         z2 <= 1'b0;
`ifdef ACT_PWL_TANH_EN
         m2 <= 1'b0;
`endif
      end else if (en2) begin
         t2 <= t;
         b2 <= s1.bias;
         z2 <= z1;
`ifdef ACT_PWL_TANH_EN
         m2 <= m1;
`endif
      end
   end

   // Add bias and clamp into [0, ONE-1]
   always_comb begin
      sum = $signed({t2[DATA_W], t2})
          + $signed({{2{b2[DATA_W-1]}}, b2});
      if (z2 || sum < 0)
         sg = '0;
      else if (sum > SMAX)
         sg = SMAX[DATA_W-1:0];
      else
         sg = sum[DATA_W-1:0];
      yn = sg;
`ifdef ACT_PWL_TANH_EN
      // 2*s - ONE stays within [-ONE, ONE-2] since s is clamped
      if (m2)
         yn = {sg[DATA_W-2:0], 1'b0} - DATA_W'(1 << FRAC_W);
`endif
   end

   // Stage 3 register drives the lane output
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         y <= '0;
      else if (en3)
         y <= yn;
   end

endmodule

// File: rtl/act_pwl_unit.sv
// act_pwl_unit: CH-lane piecewise-linear activation, shared programmable table.
// Define ACT_PWL_TANH_EN to add the cfg_mode port and tanh mode.
module act_pwl_unit
   import act_pwl_pkg::*;
#(
   parameter int DATA_W  = P_DATA_W,
   parameter int FRAC_W  = P_FRAC_W,
   parameter int NSEG    = P_NSEG,
   parameter int SHIFT_W = P_SHIFT_W,
   parameter int CH      = P_CH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CH*DATA_W-1:0]    in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CH*DATA_W-1:0]    out_data,
   input  logic                    cfg_we,
   input  logic [$clog2(NSEG)-1:0] cfg_addr,
   input  logic [DATA_W-1:0]       cfg_bp,
   input  logic [SHIFT_W-1:0]      cfg_shift,
`ifdef ACT_PWL_TANH_EN
   input  logic                    cfg_mode,
`endif
   input  logic [DATA_W-1:0]       cfg_bias
);

   seg_t tbl [NSEG];
   logic v1;
   logic v2;
   logic v3;
   logic en1;
   logic en2;
   logic en3;

`ifdef ACT_PWL_TANH_EN
   logic mode;
`endif

   // A stage moves when it is empty or the stage after it moves
   assign en3       = out_ready || !v3;
   assign en2       = en3 || !v2;
   assign en1       = en2 || !v1;
   assign in_ready  = out_ready || !v3;
   assign out_valid = v3;

   // Segment table: sigmoid on reset, one entry per write strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tbl <= SIGMOID_DEFAULT;
      else if (cfg_we)
         tbl[cfg_addr] <= '{bp: cfg_bp, shift: cfg_shift, bias: cfg_bias};
   end

`ifdef ACT_PWL_TANH_EN
   // Activation mode travels with each write
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mode <= 1'b0;
      else if (cfg_we)
         mode <= cfg_mode;
   end
`endif

   // Stage valid flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (en1) v1 <= in_valid && in_ready;
         if (en2) v2 <= v1;
         if (en3) v3 <= v2;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      act_pwl_lane #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W),
         .NSEG   (NSEG)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .en1  (en1),
         .en2  (en2),
         .en3  (en3),
`ifdef ACT_PWL_TANH_EN
         .mode (mode),
`endif
         .x    (in_data[i*DATA_W +: DATA_W]),
         .tbl  (tbl),
         .y    (out_data[i*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_act_pwl_unit.sv
// tb_act_pwl_unit: scoreboard bench for act_pwl_unit.
// Expected beats come from a reference model of the segment rule.
module tb_act_pwl_unit;

   localparam int DW   = 16;
   localparam int CH   = 4;
   localparam int NSEG = 8;
   localparam int VW   = DW * CH;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] out_data;
   logic          cfg_we;
   logic [2:0]    cfg_addr;
   logic [DW-1:0] cfg_bp;
   logic [3:0]    cfg_shift;
   logic [DW-1:0] cfg_bias;
`ifdef ACT_PWL_TANH_EN
   logic          cfg_mode = 1'b0;
`endif

   int n_vec = 0;
   int n_bad = 0;
   bit acc;

   logic [VW-1:0] exp_q [$];
   logic [VW-1:0] got_q [$];

   int mbp   [NSEG];
   int msh   [NSEG];
   int mbias [NSEG];

   act_pwl_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_bp    (cfg_bp),
      .cfg_shift (cfg_shift),
`ifdef ACT_PWL_TANH_EN
      .cfg_mode  (cfg_mode),
`endif
      .cfg_bias  (cfg_bias)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] model_lane(logic signed [DW-1:0] x);
      int k;
      int d;
      int t;
      int y;
      k = -1;
      for (int i = 0; i < NSEG; i++)
         if (mbp[i] <= int'(x)) k = i;
      if (k < 0) return '0;
      d = int'(x) - mbp[k];
      if (msh[k] == 15) t = 0;
      else t = d >>> msh[k];
      y = t + mbias[k];
      if (y < 0) y = 0;
      if (y > 255) y = 255;
      return DW'(y);
   endfunction

   function automatic logic [VW-1:0] model_vec(logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = '0;
      for (int l = 0; l < CH; l++)
         r[l*DW +: DW] = model_lane(v[l*DW +: DW]);
      return r;
   endfunction

   task automatic model_default();
      mbp   = '{-32768, -1280, -608, -256, 0, 256, 608, 1280};
      msh   = '{15, 5, 3, 2, 2, 3, 5, 15};
      mbias = '{0, 2, 22, 64, 128, 192, 235, 255};
   endtask

   // One clock: record handshakes mid-cycle, return just after the edge
   task automatic tick();
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (acc) exp_q.push_back(model_vec(in_data));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++)
         tick();
   endtask

   task automatic cfg_write(int a, logic [DW-1:0] bp,
                            logic [3:0] sh, logic [DW-1:0] b);
      cfg_we    = 1'b1;
      cfg_addr  = 3'(a);
      cfg_bp    = bp;
      cfg_shift = sh;
      cfg_bias  = b;
      tick();
      cfg_we   = 1'b0;
      mbp[a]   = int'($signed(bp));
      msh[a]   = int'(sh);
      mbias[a] = int'($signed(b));
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      n_vec++;
      if (out_data !== '0) begin
         n_bad++;
         $display("FAIL reset_out_data got %h want 0", out_data);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_linear();
      int lat;
      logic [VW-1:0] g;
      logic [VW-1:0] e;
      for (int a = 0; a < NSEG; a++)
         cfg_write(a, (a == 0) ? 16'h0000 : 16'h7FFF, 4'd0, 16'h0000);
      in_valid = 1'b1;
      in_data  = {16'h0000, 16'h0200, 16'hFFF0, 16'h0010};
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (got_q.size() == 0 && lat < 20) begin
         tick();
         lat++;
      end
      n_vec++;
      if (lat != 3) begin
         n_bad++;
         $display("FAIL linear_latency got %0d want 3", lat);
      end
      drain();
      n_vec++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         n_bad++;
         $display("FAIL linear_count got %0d want 1", got_q.size());
      end
      if (got_q.size() > 0) begin
         n_vec++;
         if (got_q[0] !== {16'h0000, 16'h00FF, 16'h0000, 16'h0010}) begin
            n_bad++;
            $display("FAIL linear_const got %h want %h", got_q[0],
                     {16'h0000, 16'h00FF, 16'h0000, 16'h0010});
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL linear_sb got %h want %h", g, e);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_zero_slope();
      logic [VW-1:0] g;
      logic [VW-1:0] e;
      cfg_write(0, 16'h0000, 4'hF, 16'h0040);
      in_valid = 1'b1;
      in_data  = {16'h7FFE, 16'h1234, 16'h0001, 16'h0000};
      tick();
      in_valid = 1'b0;
      drain();
      n_vec++;
      if (got_q.size() != 1) begin
         n_bad++;
         $display("FAIL flat_count got %0d want 1", got_q.size());
      end
      if (got_q.size() > 0) begin
         n_vec++;
         if (got_q[0] !== {4{16'h0040}}) begin
            n_bad++;
            $display("FAIL flat_const got %h want %h", got_q[0], {4{16'h0040}});
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL flat_sb got %h want %h", g, e);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] beats [16];
      logic [VW-1:0] g;
      logic [VW-1:0] e;
      int idx;
      int cyc;
      cfg_write(0, 16'h0000, 4'd0, 16'h0000);
      for (int b = 0; b < 16; b++)
         for (int l = 0; l < CH; l++)
            beats[b][l*DW +: DW] = 16'($urandom_range(0, 255));
      idx = 0;
      cyc = 0;
      while ((idx < 16 || got_q.size() < exp_q.size()) && cyc < 300) begin
         out_ready = !(cyc >= 5 && cyc <= 8);
         in_valid  = (idx < 16);
         in_data   = beats[(idx < 16) ? idx : 0];
         tick();
         if (acc) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_vec++;
      if (got_q.size() != 16 || exp_q.size() != 16) begin
         n_bad++;
         $display("FAIL stream_count got %0d want 16", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL stream_sb got %h want %h", g, e);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_cfg_same_cycle();
      logic [VW-1:0] g;
      logic [VW-1:0] e;
      in_valid  = 1'b1;
      in_data   = {4{16'h0010}};
      cfg_we    = 1'b1;
      cfg_addr  = 3'd0;
      cfg_bp    = 16'h0000;
      cfg_shift = 4'd0;
      cfg_bias  = 16'h0020;
      tick();
      cfg_we   = 1'b0;
      mbias[0] = 32;
      in_data  = {4{16'h0011}};
      tick();
      in_valid = 1'b0;
      drain();
      n_vec++;
      if (got_q.size() != 2) begin
         n_bad++;
         $display("FAIL cfg_count got %0d want 2", got_q.size());
      end
      if (got_q.size() == 2) begin
         n_vec++;
         if (got_q[0] !== {4{16'h0010}}) begin
            n_bad++;
            $display("FAIL cfg_old got %h want %h", got_q[0], {4{16'h0010}});
         end
         n_vec++;
         if (got_q[1] !== {4{16'h0031}}) begin
            n_bad++;
            $display("FAIL cfg_new got %h want %h", got_q[1], {4{16'h0031}});
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL cfg_sb got %h want %h", g, e);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_in_flight();
      logic [VW-1:0] g;
      logic [VW-1:0] e;
      logic [VW-1:0] want;
      in_valid = 1'b1;
      in_data  = {4{16'h0050}};
      tick();
      in_data  = {4{16'h0060}};
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_fly_valid got %b want 0", out_valid);
      end
      n_vec++;
      if (out_data !== '0) begin
         n_bad++;
         $display("FAIL rst_fly_data got %h want 0", out_data);
      end
      tick();
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
      model_default();
      want     = {16'h00FF, 16'h00C0, 16'h0080, 16'h0000};
      in_valid = 1'b1;
      in_data  = {16'h7FFF, 16'h0100, 16'h0000, 16'h8000};
      tick();
      in_valid = 1'b0;
      drain();
      repeat (4) tick();
      n_vec++;
      if (got_q.size() != 1) begin
         n_bad++;
         $display("FAIL rst_fly_count got %0d want 1", got_q.size());
      end
      if (got_q.size() > 0) begin
         n_vec++;
         if (got_q[0] !== want) begin
            n_bad++;
            $display("FAIL rst_fly_default got %h want %h", got_q[0], want);
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL rst_fly_sb got %h want %h", g, e);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_bp    = '0;
      cfg_shift = '0;
      cfg_bias  = '0;
      model_default();
      test_reset();
      test_linear();
      test_zero_slope();
      test_back_to_back();
      test_cfg_same_cycle();
      test_reset_in_flight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
